// File: rtl/f3m_poly_reduce.sv
// f3m_poly_reduce: sequential GF(3)[x] reducer. Brings a 2M-coefficient product
// down modulo the monic trinomial PX. Each clock cancels the top coefficient of a
// 2M-coefficient window, so one reduction takes exactly M cycles.
module f3m_poly_reduce #(
   parameter int             M  = 97,
   parameter logic [2*M+1:0] PX = 196'h4000000000000000000000000000000000000000001000002
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [4*M-1:0] a,
   output logic           busy,
   output logic           done,
   output logic [2*M-1:0] c
);

   localparam int CNT_W = $clog2(M + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [4*M-1:0]   w_q, w_d;
   logic [4*M-1:0]   w_step;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2*M-1:0]   c_q, c_d;
   logic [1:0]       q;
   logic [2*M-1:0]   t_low;

   // GF(3) addition on the 2-bit code; the illegal code 11 yields an arbitrary value.
   function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
      logic [1:0] r;
      case ({x, y})
         4'b0000: r = 2'b00;
         4'b0001: r = 2'b01;
         4'b0010: r = 2'b10;
         4'b0100: r = 2'b01;
         4'b0101: r = 2'b10;
         4'b0110: r = 2'b00;
         4'b1000: r = 2'b10;
         4'b1001: r = 2'b00;
         4'b1010: r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Negation in GF(3) is a swap of the two code bits (1 <-> 2, 0 stays 0).
   function automatic logic [1:0] gf3_neg(input logic [1:0] r);
      return {r[0], r[1]};
   endfunction

   // Multiplication by q in {0,1,2}: 2*r is -r.
   function automatic logic [1:0] gf3_mul(input logic [1:0] qv, input logic [1:0] r);
      logic [1:0] p;
      case (qv)
         2'b01:   p = r;
         2'b10:   p = gf3_neg(r);
         default: p = 2'b00;
      endcase
      return p;
   endfunction

   function automatic logic [1:0] gf3_sub(input logic [1:0] s, input logic [1:0] r);
      return gf3_add(s, gf3_neg(r));
   endfunction

   // One elimination step: subtract q*PX from the top M+1 coefficients, whose
   // leading term is then zero and is dropped as the window shifts left.
   always_comb begin
      q     = w_q[4*M-1 -: 2];
      t_low = '0;
      for (int i = 0; i < M; i++) begin
         t_low[2*i +: 2] = gf3_sub(w_q[2*M-2+2*i +: 2], gf3_mul(q, PX[2*i +: 2]));
      end
      w_step = {t_low, w_q[2*M-3:0], 2'b00};
   end

   // Sequencer next-state: load on start when idle, step M times, then publish c.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      c_d     = c_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               w_d     = a;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            w_d   = w_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(M - 1)) begin
               c_d     = w_step[4*M-1:2*M];
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset clears everything at once, aborting any reduction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         c_q     <= c_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign c    = c_q;

endmodule
